// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if
//   Fetch/EX-side bundle between the datapath and the gshare predictor.
//   master : datapath (drives pcF and EX resolution, reads prediction/stats)
//   slave  : predictor
//   Signals:
//     pcF, branchE, actually_takenE, predict_resultE, PHT_indexE  (master -> slave)
//     predict_takeF, PHT_indexF, ghr, branch_cnt, mispredict_cnt  (slave -> master)
interface gshare_predictor_if #(
    parameter int PHT_INDEX_BITS = 10,
    parameter int CNT_W          = 32
);
    logic [31:0]               pcF;
    logic                      branchE;
    logic                      actually_takenE;
    logic                      predict_resultE;
    logic [PHT_INDEX_BITS-1:0] PHT_indexE;
    logic                      predict_takeF;
    logic [PHT_INDEX_BITS-1:0] PHT_indexF;
    logic [PHT_INDEX_BITS-1:0] ghr;
    logic [CNT_W-1:0]          branch_cnt;
    logic [CNT_W-1:0]          mispredict_cnt;

    modport master (
        output pcF, branchE, actually_takenE, predict_resultE, PHT_indexE,
        input  predict_takeF, PHT_indexF, ghr, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pcF, branchE, actually_takenE, predict_resultE, PHT_indexE,
        output predict_takeF, PHT_indexF, ghr, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Fetch-stage gshare direction predictor. The PHT index is pcF word address
//   XOR global history; the MSB of the 2-bit counter at that index is the
//   prediction. Training happens only when EX resolves a branch, so history
//   is non-speculative.
//   Ports:
//     clk  - pipeline clock
//     rst  - synchronous active-high reset (wins over a same-cycle update)
//     bus  - gshare_predictor_if.slave (fetch lookup, EX training, stats)
module gshare_predictor #(
    parameter int PHT_INDEX_BITS = 10,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    gshare_predictor_if.slave   bus
);
    localparam int PHT_SIZE = 1 << PHT_INDEX_BITS;

    logic [1:0]                r_pht [PHT_SIZE];
    logic [PHT_INDEX_BITS-1:0] r_ghr;
    logic [CNT_W-1:0]          r_branch_cnt;
    logic [CNT_W-1:0]          r_mispredict_cnt;

    logic [PHT_INDEX_BITS-1:0] w_idx_f;
    logic [1:0]                w_cnt_old;
    logic [1:0]                w_cnt_new;
    logic                      w_unused_pc;

    // Only the word-address bits feed the hash.
    assign w_unused_pc = ^{bus.pcF[31:PHT_INDEX_BITS+2], bus.pcF[1:0]};

    // Lookup reads the registered array, so a same-cycle write is not bypassed.
    assign w_idx_f            = bus.pcF[PHT_INDEX_BITS+1:2] ^ r_ghr;
    assign bus.PHT_indexF     = w_idx_f;
    assign bus.predict_takeF  = r_pht[w_idx_f][1];
    assign bus.ghr            = r_ghr;
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.mispredict_cnt = r_mispredict_cnt;

    // Saturating 2-bit counter step for the EX-side entry.
    always_comb begin
        w_cnt_old = r_pht[bus.PHT_indexE];
        w_cnt_new = w_cnt_old;
        if (bus.actually_takenE) begin
            if (w_cnt_old != 2'b11) w_cnt_new = w_cnt_old + 2'd1;
        end else begin
            if (w_cnt_old != 2'b00) w_cnt_new = w_cnt_old - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) r_pht[i] <= 2'b01;
            r_ghr            <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (bus.branchE) begin
            r_pht[bus.PHT_indexE] <= w_cnt_new;
            r_ghr                 <= {r_ghr[PHT_INDEX_BITS-2:0], bus.actually_takenE};
            r_branch_cnt          <= r_branch_cnt + 1'b1;
            if (!bus.predict_resultE) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
    localparam int N = 10;
    localparam int C = 32;

    logic clk;
    logic rst;

    gshare_predictor_if #(.PHT_INDEX_BITS(N), .CNT_W(C)) bus ();

    gshare_predictor #(.PHT_INDEX_BITS(N), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         take;
        logic [N-1:0] idx;
        logic [N-1:0] ghr;
        logic [C-1:0] bc;
        logic [C-1:0] mc;
    } exp_t;

    typedef struct {
        logic         r;
        logic [31:0]  pc;
        logic         br;
        logic         tk;
        logic         pr;
        logic [N-1:0] ie;
        exp_t         e;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // reference model state
    logic [1:0]   m_pht [1 << N];
    logic [N-1:0] m_ghr;
    logic [C-1:0] m_bc, m_mc;

    function automatic void chk(string name, logic [C-1:0] act, logic [C-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < (1 << N); i++) m_pht[i] = 2'b01;
        m_ghr = '0;
        m_bc  = '0;
        m_mc  = '0;
    endfunction

    function automatic void model_update(logic r, logic br, logic tk, logic pr, logic [N-1:0] ie);
        if (r) begin
            model_reset();
        end else if (br) begin
            if (tk && m_pht[ie] != 2'd3) m_pht[ie] = m_pht[ie] + 2'd1;
            else if (!tk && m_pht[ie] != 2'd0) m_pht[ie] = m_pht[ie] - 2'd1;
            m_ghr = {m_ghr[N-2:0], tk};
            m_bc  = m_bc + 1;
            if (!pr) m_mc = m_mc + 1;
        end
    endfunction

    function automatic exp_t model_exp(logic [31:0] pc);
        exp_t e;
        e.idx  = pc[N+1:2] ^ m_ghr;
        e.take = m_pht[e.idx][1];
        e.ghr  = m_ghr;
        e.bc   = m_bc;
        e.mc   = m_mc;
        return e;
    endfunction

    function automatic vec_t mk(logic r, logic [31:0] pc, logic br, logic tk, logic pr,
                                logic [N-1:0] ie, logic take, logic [N-1:0] idx,
                                logic [N-1:0] g, int bc, int mc);
        vec_t v;
        v.r = r; v.pc = pc; v.br = br; v.tk = tk; v.pr = pr; v.ie = ie;
        v.e.take = take; v.e.idx = idx; v.e.ghr = g;
        v.e.bc = C'(bc); v.e.mc = C'(mc);
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("predict_takeF", C'(bus.predict_takeF), C'(e.take));
        chk("PHT_indexF", C'(bus.PHT_indexF), C'(e.idx));
        chk("ghr", C'(bus.ghr), C'(e.ghr));
        chk("branch_cnt", bus.branch_cnt, e.bc);
        chk("mispredict_cnt", bus.mispredict_cnt, e.mc);
    endtask

    // Drive one cycle: inputs just after posedge, compare on negedge,
    // advance the model at the next posedge.
    task automatic step(logic r, logic [31:0] pc, logic br, logic tk, logic pr,
                        logic [N-1:0] ie, exp_t e);
        rst                 = r;
        bus.pcF             = pc;
        bus.branchE         = br;
        bus.actually_takenE = tk;
        bus.predict_resultE = pr;
        bus.PHT_indexE      = ie;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        model_update(r, br, tk, pr, ie);
        #1;
    endtask

    task automatic stepm(logic r, logic [31:0] pc, logic br, logic tk, logic pr, logic [N-1:0] ie);
        step(r, pc, br, tk, pr, ie, model_exp(pc));
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        bus.pcF = 32'h40; bus.branchE = 0; bus.actually_takenE = 0;
        bus.predict_resultE = 1; bus.PHT_indexE = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // ---- directed table (constant expectations) ----
        //            r  pc     br tk pr ie      take idx     ghr    bc mc
        tbl.push_back(mk(0, 32'h40, 0, 0, 1, 10'h000, 0, 10'h010, 10'h0, 0, 0));
        tbl.push_back(mk(0, 32'h40, 1, 1, 1, 10'h010, 0, 10'h010, 10'h0, 0, 0));
        tbl.push_back(mk(0, 32'h40, 1, 1, 1, 10'h010, 0, 10'h011, 10'h1, 1, 0));
        tbl.push_back(mk(0, 32'h40, 0, 0, 1, 10'h000, 0, 10'h013, 10'h3, 2, 0));
        tbl.push_back(mk(0, 32'h4C, 0, 0, 1, 10'h000, 1, 10'h010, 10'h3, 2, 0));
        tbl.push_back(mk(1, 32'h4C, 0, 0, 1, 10'h000, 1, 10'h010, 10'h3, 2, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 32'h14, 1, 0, 0, 10'h005, 0, 10'h005, 10'h0, k, k));
        tbl.push_back(mk(0, 32'h14, 1, 1, 0, 10'h005, 0, 10'h005, 10'h0, 5, 5));
        tbl.push_back(mk(0, 32'h10, 1, 1, 1, 10'h005, 0, 10'h005, 10'h1, 6, 6));
        tbl.push_back(mk(0, 32'h18, 0, 0, 1, 10'h000, 1, 10'h005, 10'h3, 7, 6));
        foreach (tbl[i]) step(tbl[i].r, tbl[i].pc, tbl[i].br, tbl[i].tk, tbl[i].pr, tbl[i].ie, tbl[i].e);

        // ---- same-cycle read/write of entry 0x020 ----
        stepm(1, 32'h80, 0, 0, 1, '0);
        stepm(0, 32'h80, 1, 1, 1, 10'h020);       // lookup sees pre-update 01
        stepm(0, 32'h84, 0, 0, 1, '0);            // 0x021^1 = 0x020, now 10
        chk("same_cycle_next_take", C'(bus.predict_takeF), 1);

        // ---- stats counters ----
        stepm(1, 32'h0, 0, 0, 1, '0);
        stepm(0, 32'h0, 1, 1, 1, 10'h001);
        stepm(0, 32'h0, 1, 0, 0, 10'h002);
        stepm(0, 32'h0, 1, 1, 1, 10'h003);
        stepm(0, 32'h0, 1, 1, 0, 10'h004);
        stepm(0, 32'h0, 1, 0, 0, 10'h005);
        for (int k = 0; k < 3; k++) stepm(0, 32'h0, 0, 1, 0, 10'h006);
        chk("stats_branch_cnt", bus.branch_cnt, 5);
        chk("stats_mispredict_cnt", bus.mispredict_cnt, 3);

        // ---- reset in the same cycle as a training update ----
        stepm(0, 32'h40, 1, 1, 1, 10'h010);
        stepm(0, 32'h40, 1, 1, 1, 10'h010);
        stepm(1, 32'h40, 1, 1, 0, 10'h010);
        chk("rst_win_ghr", C'(bus.ghr), 0);
        chk("rst_win_bcnt", bus.branch_cnt, 0);
        chk("rst_win_take", C'(bus.predict_takeF), 0);

        // ---- random traffic against the model ----
        for (int k = 0; k < 10000; k++) begin
            logic [31:0] pc;
            logic br, tk, pr;
            logic [N-1:0] ie;
            pc = $urandom;
            br = ($urandom_range(0, 2) != 0);
            tk = $urandom_range(0, 1);
            pr = $urandom_range(0, 1);
            ie = N'($urandom_range(0, 15));   // small index set to reach saturation
            stepm(0, pc, br, tk, pr, ie);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
